// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types (package)
// Brief    : Branch-predictor update scheduler defaults, state enum and the
//            2-bit counter update function.
// Revision : 1.0
// ============================================================================
package rv32i_types;

    localparam int c_GHR_DEPTH    = 30;
    localparam int c_PHT_DEPTH    = 10;
    localparam int c_QDEPTH       = 4;
    localparam int c_STARVE_LIMIT = 8;

    localparam logic [1:0] c_CTR_INIT = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RMW_CAP = 2'd2,
        ST_RMW_WR  = 2'd3
    } bp_sched_state_t;

    // A mispredict moves the counter toward the opposite direction; a correct
    // prediction only strengthens the weak states.
    function automatic logic [1:0] bp_ctr_next(input logic [1:0] old_ctr,
                                               input logic       mispredict);
        logic [1:0] result;
        result = old_ctr;
        if (mispredict) begin
            result = old_ctr[1] ? (old_ctr - 2'd1) : (old_ctr + 2'd1);
        end else begin
            case (old_ctr)
                2'b10:   result = 2'b11;
                2'b01:   result = 2'b00;
                default: result = old_ctr;
            endcase
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_update_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_fifo
// Brief    : Small synchronous FIFO holding pending PHT updates.
// Revision : 1.0
// ============================================================================
module bp_update_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full       = (r_count == c_CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign push_ready = !full;
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop && !empty;
    assign head_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_scheduler
// Brief    : Arbitrates a single PHT port between fetch lookups and queued
//            read-modify-write counter updates; owns the global history.
// Revision : 1.0
// ============================================================================
module bp_update_scheduler
    import rv32i_types::*;
#(
    parameter int GHR_DEPTH    = c_GHR_DEPTH,
    parameter int PHT_DEPTH    = c_PHT_DEPTH,
    parameter int QDEPTH       = c_QDEPTH,
    parameter int STARVE_LIMIT = c_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_valid,
    input  logic                 commit_taken,
    input  logic                 commit_mispredict,
    input  logic [31:0]          commit_pc,
    output logic                 commit_ready,
    input  logic                 fetch_req,
    input  logic [31:0]          fetch_pc,
    output logic                 fetch_gnt,
    output logic                 fetch_rsp_valid,
    output logic                 fetch_take,
    output logic                 pht_en,
    output logic                 pht_we,
    output logic [PHT_DEPTH-1:0] pht_addr,
    output logic [1:0]           pht_wdata,
    input  logic [1:0]           pht_rdata,
    output logic [GHR_DEPTH-1:0] ghr
);
    localparam int c_ENTRY_W = PHT_DEPTH + 1;
    localparam int c_SW      = $clog2(STARVE_LIMIT + 1);

    bp_sched_state_t      r_state, w_state_nxt;
    logic [PHT_DEPTH-1:0] r_init_addr;
    logic [GHR_DEPTH-1:0] r_ghr;
    logic [c_SW-1:0]      r_starve;
    logic [1:0]           r_new_ctr;
    logic                 r_rsp_valid;

    logic                 w_fifo_ready, w_fifo_full, w_fifo_empty;
    logic                 w_push, w_pop;
    logic [c_ENTRY_W-1:0] w_head;
    logic [PHT_DEPTH-1:0] w_commit_idx, w_fetch_idx;
    logic                 w_upd_pending, w_force, w_upd_issue;
    logic                 w_unused;

    assign w_commit_idx = r_ghr[PHT_DEPTH-1:0] ^ commit_pc[PHT_DEPTH+1:2];
    assign w_fetch_idx  = r_ghr[PHT_DEPTH-1:0] ^ fetch_pc[PHT_DEPTH+1:2];

    assign commit_ready = !rst && (r_state != ST_INIT) && w_fifo_ready;
    assign w_push       = commit_valid && commit_ready;

    // An update is pending whenever it could use the port this cycle; it only
    // loses to fetch until the starvation counter saturates.
    assign w_upd_pending = ((r_state == ST_IDLE) && !w_fifo_empty) || (r_state == ST_RMW_WR);
    assign w_force       = (r_starve >= c_SW'(STARVE_LIMIT));
    assign w_upd_issue   = !rst && w_upd_pending && (!fetch_req || w_force);
    assign fetch_gnt     = !rst && fetch_req && (r_state != ST_INIT) && !w_upd_issue;
    assign w_pop         = w_upd_issue && (r_state == ST_RMW_WR);

    assign fetch_rsp_valid = !rst && r_rsp_valid;
    assign fetch_take      = fetch_rsp_valid && pht_rdata[1];
    assign ghr             = r_ghr;

    assign w_unused = ^{commit_pc[31:PHT_DEPTH+2], commit_pc[1:0],
                        fetch_pc[31:PHT_DEPTH+2], fetch_pc[1:0], w_fifo_full};

    bp_update_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (w_push),
        .push_ready (w_fifo_ready),
        .push_data  ({commit_mispredict, w_commit_idx}),
        .pop        (w_pop),
        .head_data  (w_head),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        pht_en      = 1'b0;
        pht_we      = 1'b0;
        pht_addr    = '0;
        pht_wdata   = '0;
        case (r_state)
            ST_INIT: begin
                pht_en    = 1'b1;
                pht_we    = 1'b1;
                pht_addr  = r_init_addr;
                pht_wdata = c_CTR_INIT;
                if (&r_init_addr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_upd_issue) begin
                    pht_en      = 1'b1;
                    pht_addr    = w_head[PHT_DEPTH-1:0];
                    w_state_nxt = ST_RMW_CAP;
                end
            end
            ST_RMW_CAP: begin
                w_state_nxt = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                if (w_upd_issue) begin
                    pht_en      = 1'b1;
                    pht_we      = 1'b1;
                    pht_addr    = w_head[PHT_DEPTH-1:0];
                    pht_wdata   = r_new_ctr;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (fetch_gnt) begin
            pht_en   = 1'b1;
            pht_addr = w_fetch_idx;
        end
        if (rst) begin
            pht_en = 1'b0;
            pht_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_init_addr <= '0;
            r_ghr       <= '0;
            r_starve    <= '0;
            r_new_ctr   <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= fetch_gnt;
            if (r_state == ST_INIT) begin
                r_init_addr <= r_init_addr + PHT_DEPTH'(1);
            end
            if (w_push) begin
                r_ghr <= {r_ghr[GHR_DEPTH-2:0], commit_taken};
            end
            if (w_upd_issue) begin
                r_starve <= '0;
            end else if (w_upd_pending) begin
                r_starve <= r_starve + c_SW'(1);
            end
            if (r_state == ST_RMW_CAP) begin
                r_new_ctr <= bp_ctr_next(pht_rdata, w_head[PHT_DEPTH]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_scheduler
// Brief    : Directed self-checking bench with a behavioural PHT memory.
// Revision : 1.0
// ============================================================================
module tb_bp_update_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, commit_taken, commit_mispredict;
    logic [31:0] commit_pc;
    logic        commit_ready;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_gnt, fetch_rsp_valid, fetch_take;
    logic        pht_en, pht_we;
    logic [9:0]  pht_addr;
    logic [1:0]  pht_wdata, pht_rdata;
    logic [29:0] ghr;

    logic [1:0]  mem [0:1023];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ops[$];
    int          n_acc;

    always #5 clk = ~clk;

    bp_update_scheduler u_dut (
        .clk               (clk),
        .rst               (rst),
        .commit_valid      (commit_valid),
        .commit_taken      (commit_taken),
        .commit_mispredict (commit_mispredict),
        .commit_pc         (commit_pc),
        .commit_ready      (commit_ready),
        .fetch_req         (fetch_req),
        .fetch_pc          (fetch_pc),
        .fetch_gnt         (fetch_gnt),
        .fetch_rsp_valid   (fetch_rsp_valid),
        .fetch_take        (fetch_take),
        .pht_en            (pht_en),
        .pht_we            (pht_we),
        .pht_addr          (pht_addr),
        .pht_wdata         (pht_wdata),
        .pht_rdata         (pht_rdata),
        .ghr               (ghr)
    );

    always @(posedge clk) begin
        if (pht_en) begin
            if (pht_we) mem[pht_addr] <= pht_wdata;
            else        pht_rdata     <= mem[pht_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Port op code: write = 4096 | data<<10 | addr, read = addr.
    task automatic log_cycle();
        if (pht_en)
            ops.push_back(pht_we ? (4096 | (int'(pht_wdata) << 10) | int'(pht_addr)) : int'(pht_addr));
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= q.size()) return -1;
        return q[i];
    endfunction

    function automatic int n_writes();
        int n = 0;
        foreach (ops[i]) if (ops[i] >= 4096) n++;
        return n;
    endfunction

    task automatic run_init(input string tag);
        int gnt_n = 0;
        int bad   = 0;
        ops.delete();
        for (int k = 0; k < 1100; k++) begin
            #1;
            if (commit_ready) break;
            if (fetch_gnt) gnt_n++;
            log_cycle();
            @(negedge clk);
        end
        foreach (ops[i]) if (ops[i] != (4096 | (1 << 10) | i)) bad++;
        check_val({tag, "_init_count"}, ops.size(), 1024);
        check_val({tag, "_init_seq"}, bad, 0);
        check_val({tag, "_init_gnt"}, gnt_n, 0);
        check_val({tag, "_ready_after_init"}, commit_ready, 1);
        fetch_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int rd_t[$], wr_t[$], wr_codes[$];
        int gnt_bad, take_bad, found;
        int exp_idx[5] = '{7, 14, 28, 56, 112};

        rst = 1'b1; commit_valid = 1'b1; commit_taken = 1'b1; commit_mispredict = 1'b0;
        commit_pc = 32'h10; fetch_req = 1'b1; fetch_pc = 32'h0;

        // Reset state
        @(negedge clk);
        #1;
        check_val("rst_commit_ready", commit_ready, 0);
        check_val("rst_fetch_gnt", fetch_gnt, 0);
        check_val("rst_pht_en", pht_en, 0);
        check_val("rst_rsp_valid", fetch_rsp_valid, 0);
        check_val("rst_take", fetch_take, 0);
        @(negedge clk);
        rst = 1'b0; commit_valid = 1'b0;
        run_init("boot");

        // Mispredicted taken commit then a fetch hitting the same entry
        ops.delete();
        #1 check_val("ghr_zero", ghr, 0);
        @(negedge clk);
        commit_valid = 1'b1; commit_pc = 32'h10; commit_taken = 1'b1; commit_mispredict = 1'b1;
        #1 check_val("c1_ready", commit_ready, 1);
        log_cycle();
        @(negedge clk);
        commit_valid = 1'b0;
        #1 check_val("c1_ghr", ghr, 1);
        for (int k = 0; k < 20; k++) begin
            #1; log_cycle(); @(negedge clk);
            if (n_writes() != 0) break;
        end
        check_val("c1_ops", ops.size(), 2);
        check_val("c1_read", qget(ops, 0), 4);
        check_val("c1_write", qget(ops, 1), 4096 | (2 << 10) | 4);
        fetch_req = 1'b1; fetch_pc = 32'h14;
        #1;
        check_val("f1_gnt", fetch_gnt, 1);
        check_val("f1_addr", pht_addr, 4);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        check_val("f1_rsp_valid", fetch_rsp_valid, 1);
        check_val("f1_take", fetch_take, 1);
        @(negedge clk);

        // Back-to-back correct commits to idx 4 (counter 10)
        ops.delete();
        commit_valid = 1'b1; commit_pc = 32'h14; commit_taken = 1'b1; commit_mispredict = 1'b0;
        #1 log_cycle();
        @(negedge clk);
        commit_pc = 32'h1C;
        #1 log_cycle();
        @(negedge clk);
        commit_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (n_writes() == 2) break;
            #1; log_cycle(); @(negedge clk);
        end
        check_val("b2b_ops", ops.size(), 4);
        check_val("b2b_rd1", qget(ops, 0), 4);
        check_val("b2b_wr1", qget(ops, 1), 4096 | (3 << 10) | 4);
        check_val("b2b_rd2", qget(ops, 2), 4);
        check_val("b2b_wr2", qget(ops, 3), 4096 | (3 << 10) | 4);
        check_val("b2b_ghr", ghr, 7);

        // Five commits under continuous fetch pressure
        n_acc = 0; gnt_bad = 0; take_bad = 0;
        fetch_req = 1'b1; fetch_pc = 32'h100;
        commit_pc = 32'h0; commit_taken = 1'b0; commit_mispredict = 1'b0;
        for (int t = 0; t < 400; t++) begin
            commit_valid = (n_acc < 5);
            #1;
            if (t == 4) begin
                check_val("q_ready_after_4", commit_ready, 0);
                check_val("q_accepted_4", n_acc, 4);
            end
            if (pht_en && !pht_we && !fetch_gnt) rd_t.push_back(t);
            if (pht_en && pht_we) begin
                wr_t.push_back(t);
                wr_codes.push_back(int'(pht_addr) | (int'(pht_wdata) << 10));
                if (fetch_gnt) gnt_bad++;
            end
            if (fetch_take && !fetch_rsp_valid) take_bad++;
            if (commit_valid && commit_ready) n_acc++;
            @(negedge clk);
            if (wr_t.size() == 5) break;
        end
        commit_valid = 1'b0;
        check_val("q_accepted", n_acc, 5);
        check_val("q_writes", wr_t.size(), 5);
        check_val("q_first_read_t", qget(rd_t, 0), 9);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("q_gap%0d", i), qget(wr_t, i) - qget(rd_t, i), 10);
            check_val($sformatf("q_wr%0d", i), qget(wr_codes, i), exp_idx[i]);
        end
        check_val("q_gnt_on_write", gnt_bad, 0);
        check_val("q_take_no_rsp", take_bad, 0);

        // Reset while an update sits in RMW_WR
        found = 0;
        commit_pc = 32'h40; commit_taken = 1'b1; commit_mispredict = 1'b1;
        for (int k = 0; k < 40; k++) begin
            commit_valid = (k < 2);
            #1;
            if (pht_en && !pht_we && !fetch_gnt) found = 1;
            @(negedge clk);
            if (found != 0) break;
        end
        commit_valid = 1'b0;
        check_val("r_found_read", found, 1);
        @(negedge clk);
        #1;
        check_val("r_wr_held_gnt", fetch_gnt, 1);
        check_val("r_wr_held_we", pht_we, 0);
        rst = 1'b1; fetch_req = 1'b0;
        #1;
        check_val("r_no_write_en", pht_en, 0);
        check_val("r_no_write_we", pht_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("r_ghr", ghr, 0);
        check_val("r_ready", commit_ready, 0);
        run_init("rerun");
        ops.delete();
        repeat (20) begin
            #1; log_cycle(); @(negedge clk);
        end
        check_val("r_queue_empty", ops.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
